// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO and result register around the combinational ALU stage.
//
// Commands {x, y, op} arrive over a valid/ready handshake and are queued in a DEPTH-entry
// FIFO. The head entry drives the ALU directly. The ALU result is captured into a result
// register that has its own valid/ready handshake.
//
// Optional feature: define ALU_CMD_QUEUE_DIV0_TRAP_EN to trap divide-by-zero. When an
// opcode 4'b0011 with y == 0 is captured, out_z is forced to 8'hFF and out_err is set.
// When the macro is undefined, out_err is tied to 0.
//
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   in_valid/in_ready           command handshake
//   in_x, in_y, in_op           command operands and opcode
//   alu_x, alu_y, alu_op        head entry to the ALU (0 when the queue is empty)
//   alu_z                       combinational ALU result
//   out_valid/out_ready         result handshake
//   out_z, out_op, out_err      registered result, its opcode and the error flag
//   done_cnt                    saturating count of results handed downstream
module alu_cmd_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_x,
  input  logic [3:0]       in_y,
  input  logic [3:0]       in_op,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_z,
  output logic [3:0]       out_op,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [11:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             out_valid_q;
  logic [7:0]       out_z_q;
  logic [3:0]       out_op_q;
  logic [CNT_W-1:0] done_cnt_q;

  logic        not_empty, push, pop, handoff;
  logic [11:0] head;
  logic [7:0]  cap_z;

  // in_ready depends only on the registered count: a pop in the same cycle never frees a slot.
  assign in_ready  = (count_q != Full);
  assign not_empty = (count_q != '0);
  assign push      = in_valid && in_ready;
  // Capture whenever the result register is empty or being drained this cycle.
  assign pop       = not_empty && (!out_valid_q || out_ready);
  assign handoff   = out_valid_q && out_ready;

  assign head = not_empty ? mem_q[rd_ptr_q] : 12'h000;
  assign {alu_x, alu_y, alu_op} = head;

`ifdef ALU_CMD_QUEUE_DIV0_TRAP_EN
  logic cap_err;
  logic out_err_q;

  always_comb begin
    cap_z   = alu_z;
    cap_err = 1'b0;
    if (alu_op == 4'b0011 && alu_y == 4'h0) begin
      cap_z   = 8'hFF;
      cap_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_q <= 1'b0;
    end else if (pop) begin
      out_err_q <= cap_err;
    end
  end

  assign out_err = out_err_q;
`else
  assign cap_z   = alu_z;
  assign out_err = 1'b0;
`endif

  // Storage needs no reset: entries are only observed when count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_x, in_y, in_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= 8'h00;
      out_op_q    <= 4'h0;
      done_cnt_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end

      if (pop) begin
        out_valid_q <= 1'b1;
        out_z_q     <= cap_z;
        out_op_q    <= alu_op;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end

      if (handoff && (done_cnt_q != '1)) begin
        done_cnt_q <= done_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_op    = out_op_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: doc/alu_cmd_queue.md
# alu_cmd_queue

Upstream command buffer and result register for the 4-bit combinational ALU stage (`alu_bh_1`). It accepts operand/opcode commands over a valid/ready handshake, queues them in a DEPTH-entry FIFO, and presents the head entry to the ALU. It captures the ALU's 8-bit result in an output register with its own valid/ready handshake. This turns the purely combinational ALU into a flow-controlled, back-pressurable pipeline stage.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `CNT_W`, default 16: width of the completed-result counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command present.
- `in_ready` out 1: queue can accept.
- `in_x` in 4: operand x.
- `in_y` in 4: operand y.
- `in_op` in 4: ALU opcode.
- `alu_x` out 4: head operand x to ALU.
- `alu_y` out 4: head operand y to ALU.
- `alu_op` out 4: head opcode to ALU.
- `alu_z` in 8: ALU combinational result.
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: downstream accepts the result.
- `out_z` out 8: registered result.
- `out_op` out 4: opcode that produced `out_z`.
- `out_err` out 1: error flag (see Configuration).
- `done_cnt` out CNT_W: results handed off downstream, saturating.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes {x,y,op} to the tail. Pointers wrap modulo DEPTH.
- `in_ready = (count != DEPTH)`, combinational from the registered count. No pass-through when full: a pop in the same cycle does not raise `in_ready`.
- `alu_x/alu_y/alu_op` drive the head entry directly from storage. They are 0 when empty.
- Pop/capture: when `count != 0 && (!out_valid || out_ready)`, the next edge pops the head and loads `out_z <= alu_z`, `out_op <= alu_op`, `out_valid <= 1`.
- Drain: `out_valid && out_ready` with no capture clears `out_valid` at the next edge. Handoff and capture in the same cycle keep `out_valid=1` with the new data.
- `done_cnt` increments on every `out_valid && out_ready` edge. It saturates at all-ones.
- Simultaneous push and pop leave `count` unchanged. Push into an empty queue is not visible at the head until the following cycle.
- `out_z`, `out_op`, `out_err` hold stable while `out_valid && !out_ready`.
- Result width: `out_z` is exactly the ALU's 8-bit value. No re-extension is applied; subtraction underflow wraps mod 256.

## Timing
- Reset (async assert, `rst_n=0`):
  - count, pointers, `out_valid`, `out_z`, `out_op`, `out_err`, `done_cnt` = 0.
  - `alu_*` = 0.
  - `in_ready`=1, but pushes are ignored while `rst_n=0`.
- Reset deasserts synchronously to logic. The first push is honoured at the first rising edge with `rst_n=1`.
- Reset mid-operation discards all queued commands and any pending result immediately. No output pulse follows.
- Latency, empty queue and free output: command accepted at edge k → head visible after k → captured at k+1 → `out_valid=1` after k+1. That is 2 edges.
- Throughput: 1 result/cycle sustained when `out_ready=1`.
- Capacity under stall: DEPTH queued plus 1 in the result register.

## Configuration
- Macro: `ALU_CMD_QUEUE_DIV0_TRAP_EN`.
- Defined:
  - On capture of opcode `4'b0011` with `alu_y==0`: `out_z <= 8'hFF`, `out_err <= 1`.
  - All other captures: `out_err <= 0`.
- Undefined:
  - `out_err` is tied to 0.
  - `out_z` always takes `alu_z` unmodified.

## Test plan
- Reset, push x=3, y=5, op=0000 with `out_ready=1` → `out_valid` high 2 edges after accept, `out_z=8'h08`, `out_op=0000`, `done_cnt=1`.
- Push x=15, y=15, op=0010, then x=2, y=5, op=0001 back-to-back → consecutive results `8'hE1` then `8'hFD`, no bubble.
- `out_ready=0`, DEPTH=4, continuous `in_valid` → exactly 5 commands accepted, then `in_ready=0`. Raise `out_ready` → 5 results in order, `done_cnt=5`.
- Push x=9, y=0, op=0011:
  - Macro defined → `out_z=8'hFF`, `out_err=1`.
  - Macro undefined → `out_err=0`, `out_z` equals ALU output.
- Fill 3 entries with `out_ready=0`, assert `rst_n=0` mid-cycle → `out_valid`, count, and `done_cnt` drop to 0 without waiting for an edge. After release, a new push yields the correct single result.
- Hold `out_valid` with `out_ready=0` for 10 cycles while pushing → `out_z`/`out_op` stable throughout. `done_cnt` unchanged until handoff.
